uart_tx_framer: RTL and testbench

Parametrised UART transmit framer that supersedes the fixed 2-bit-select output mux stage.
- Accepts a parallel word over a valid/ready handshake.
- Serialises it LSB-first with start bit, optional even/odd parity and 1 or 2 stop bits.
- Drives a registered serial line at one bit per CLK cycle; CLK is the bit-rate clock from the existing prescaler.
- Sits between the TX data source (FIFO/controller) and the UART pad.

---
 rtl/uart_tx_pkg.sv | 24 ++
 rtl/uart_tx_parity.sv | 14 +
 rtl/uart_tx_framer.sv | 137 +++++++++++++
 tb/tb_uart_tx_framer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity types, line level.
package uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP1  = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP1  = ST_STOP1,
    S_STOP2  = ST_STOP2
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity generator, shared between the TX framer and the RX checker.
module uart_tx_parity
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first payload, optional parity, 1 or 2 stop bits,
// one bit per CLK with a registered line output.
module uart_tx_framer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  TX_READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  FRAME_DONE
);

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  par_q, par_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  tx_out_q, tx_out_d;
  logic                  frame_done_q, frame_done_d;

  logic                  par_bit;
  logic                  last_stop;
  logic                  accept;
  logic [DATA_WIDTH-1:0] data_shifted;

  uart_tx_parity #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data   (P_DATA),
    .par_typ(PAR_TYP),
    .par_bit(par_bit)
  );

  // The final stop bit can overlap acceptance of the next word, so frames abut.
  assign last_stop = ((state_q == S_STOP1) && !stop2_q) || (state_q == S_STOP2);
  assign TX_READY  = (state_q == S_IDLE) || last_stop;
  assign accept    = DATA_VALID && TX_READY;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    par_en_d     = par_en_q;
    stop2_d      = stop2_q;
    par_d        = par_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;

    if (accept) begin
      data_d    = P_DATA;
      par_en_d  = PAR_EN;
      stop2_d   = STOP2;
      par_d     = par_bit;
      bit_cnt_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_START;
      end
      S_START: begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
      end
      S_DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = par_en_q ? S_PARITY : S_STOP1;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
        end
      end
      S_PARITY: state_d = S_STOP1;
      S_STOP1: begin
        if (stop2_q) begin
          state_d = S_STOP2;
        end else begin
          frame_done_d = 1'b1;
          state_d      = accept ? S_START : S_IDLE;
        end
      end
      S_STOP2: begin
        frame_done_d = 1'b1;
        state_d      = accept ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line value is derived from the state being entered, so TX_OUT lines up with it.
  assign data_shifted = data_d >> bit_cnt_d;

  always_comb begin
    tx_out_d = LINE_IDLE;
    case (state_d)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = data_shifted[0];
      S_PARITY: tx_out_d = par_d;
      default:  tx_out_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      par_en_q     <= 1'b0;
      stop2_q      <= 1'b0;
      par_q        <= 1'b0;
      bit_cnt_q    <= '0;
      tx_out_q     <= LINE_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      par_en_q     <= par_en_d;
      stop2_q      <= stop2_d;
      par_q        <= par_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_out_q     <= tx_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign TX_OUT     = tx_out_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: directed frames plus randomized traffic
// against a bit-queue model of the serial line.
module tb_uart_tx_framer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] p_data = '0;
  logic         data_valid = 1'b0;
  logic         par_en = 1'b0;
  logic         par_typ = 1'b0;
  logic         stop2 = 1'b0;
  logic         tx_ready;
  logic         tx_out;
  logic         frame_done;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int fd_cnt    = 0;

  // Model: front of mq is the bit currently on the line; empty means idle.
  bit mq[$];
  bit obs[$];
  bit accepted;
  bit fd_exp;

  uart_tx_framer #(
    .DATA_WIDTH(W),
    .CNT_WIDTH (4)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .P_DATA    (p_data),
    .DATA_VALID(data_valid),
    .TX_READY  (tx_ready),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .STOP2     (stop2),
    .TX_OUT    (tx_out),
    .FRAME_DONE(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic got, input logic exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %b expected %b at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d, input bit pe, input bit pt, input bit s2);
    int ones;
    ones = 0;
    mq.push_back(1'b0);
    for (int i = 0; i < W; i++) begin
      mq.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) mq.push_back(bit'(ones % 2) ^ pt);
    mq.push_back(1'b1);
    if (s2) mq.push_back(1'b1);
  endtask

  // Advance one clock: update the model from the inputs, then check the DUT after the edge.
  task automatic tick();
    bit ready_m;
    ready_m  = (mq.size() <= 1);
    accepted = 1'b0;
    if (!rst) begin
      mq.delete();
      fd_exp = 1'b0;
    end else begin
      fd_exp = (mq.size() == 1);
      if (mq.size() != 0) void'(mq.pop_front());
      if (data_valid && ready_m) begin
        push_frame(p_data, par_en, par_typ, stop2);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    obs.push_back(tx_out);
    if (frame_done === 1'b1) fd_cnt++;
    chk("tx_out", tx_out, (mq.size() != 0) ? mq[0] : 1'b1);
    chk("frame_done", frame_done, fd_exp);
    chk("tx_ready", tx_ready, mq.size() <= 1);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [W-1:0] d, input bit pe, input bit pt, input bit s2,
                      input bit hold, output int start_idx);
    int n;
    n = 0;
    p_data = d; par_en = pe; par_typ = pt; stop2 = s2;
    data_valid = 1'b1;
    accepted = 1'b0;
    while (!accepted && n < 100) begin
      tick();
      n++;
    end
    chk("accept_timeout", accepted, 1'b1);
    start_idx = obs.size() - 1;
    if (!hold) data_valid = 1'b0;
  endtask

  initial begin
    int s, s1, s2i, fd_before;
    logic [9:0] exp_a5;
    logic [W-1:0] word;
    bit have;

    // Reset then idle
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(4);

    // 0xA5, no parity, one stop
    fd_before = fd_cnt;
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, s);
    idle(12);
    exp_a5 = 10'b1101001010;
    for (int i = 0; i < 10; i++) chk("a5_line_bit", obs[s + i], exp_a5[i]);
    chk("a5_after_frame_idle", obs[s + 10], 1'b1);
    chk_int("a5_frame_done_count", fd_cnt - fd_before, 1);

    // Even then odd parity on 0x03
    send(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, s);
    idle(12);
    chk("par_even_bit", obs[s + 9], 1'b0);
    chk("par_even_stop", obs[s + 10], 1'b1);
    send(8'h03, 1'b1, 1'b1, 1'b0, 1'b0, s);
    idle(12);
    chk("par_odd_bit", obs[s + 9], 1'b1);

    // Two stop bits, odd parity, all ones
    fd_before = fd_cnt;
    send(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, s);
    idle(14);
    chk("ff_par_bit", obs[s + 9], 1'b1);
    chk_int("ff_frame_done_count", fd_cnt - fd_before, 1);

    // Back-to-back frames with valid held high
    fd_before = fd_cnt;
    send(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, s1);
    send(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, s2i);
    idle(12);
    chk_int("b2b_start_spacing", s2i - s1, 10);
    chk_int("b2b_frame_done_count", fd_cnt - fd_before, 2);

    // Reset during data bit 4 of 0x0F
    fd_before = fd_cnt;
    send(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, s);
    idle(5);
    chk("rst_pre_bit4", obs[s + 5], 1'b0);
    rst = 1'b0;
    tick();
    chk("rst_line_high", tx_out, 1'b1);
    chk_int("rst_no_frame_done", fd_cnt - fd_before, 0);
    rst = 1'b1;
    idle(2);
    send(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, s);
    idle(14);
    chk_int("post_rst_frame_done", fd_cnt - fd_before, 1);

    // Randomized traffic: word held until accepted, config jittered every cycle
    have = 1'b0;
    word = '0;
    for (int c = 0; c < 600; c++) begin
      if (!have) begin
        word = W'($urandom);
        have = 1'b1;
      end
      p_data     = word;
      data_valid = ($urandom_range(3) != 0);
      par_en     = 1'($urandom);
      par_typ    = 1'($urandom);
      stop2      = 1'($urandom);
      rst        = ($urandom_range(199) != 0);
      tick();
      if (accepted) have = 1'b0;
    end
    rst = 1'b1;
    data_valid = 1'b0;
    idle(16);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
